// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Sequencer state, kept as plain constants so older code can compare against raw bits
  typedef logic [0:0] state_t;
  localparam state_t RUN      = 1'b0;
  localparam state_t MEM_WAIT = 1'b1;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  // MemtoReg value the MEM/WB register takes when memwb_bubble is asserted
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;

  // Per-cycle control bundle driven to the pipeline registers and the PC
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_bubble;
  } ctrl_t;

  function automatic ctrl_t ctrl_advance();
    ctrl_t c;
    c = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
          idex_flush: 1'b0, exmem_en: 1'b1, memwb_bubble: 1'b0};
    return c;
  endfunction

  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0,
          idex_flush: 1'b1, exmem_en: 1'b0, memwb_bubble: 1'b1};
    return c;
  endfunction

  function automatic ctrl_t ctrl_hold();
    ctrl_t c;
    c = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0,
          idex_flush: 1'b0, exmem_en: 1'b0, memwb_bubble: 1'b1};
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       lu_hazard
);

  // $zero never carries a real dependency, so a load targeting it never stalls
  always_comb begin
    lu_hazard = idex_memread && (idex_rt != REG_ZERO) &&
                ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: branch/jump squash, load-use
// bubble, memory-wait hold with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_tkn,
  input  logic             id_jump,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t          state;
  state_t          state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic [WC_W-1:0] wait_cnt_nxt;
  logic            lu_hazard;
  logic            wait_cyc;
  logic            timeout;
  logic            hold;
  ctrl_t           ctrl;

  load_use_detect u_load_use_detect (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .lu_hazard    (lu_hazard)
  );

  // A wait cycle is any cycle the MEM-stage access is outstanding, including
  // the RUN cycle that first sees it, so the timeout bounds total wait length.
  assign wait_cyc = ~dmem_ready & ((state == MEM_WAIT) | dmem_req);
  assign timeout  = wait_cyc & (wait_cnt == WC_LAST);
  assign hold     = wait_cyc & ~timeout;

  // Output priority mux; reset overrides combinationally so it acts immediately
  always_comb begin
    ctrl        = ctrl_advance();
    mem_timeout = 1'b0;
    if (reset) begin
      ctrl = ctrl_reset();
    end else if (hold) begin
      // Upstream hazards are ignored here; they re-evaluate once stages move again
      ctrl = ctrl_hold();
    end else begin
      if (ex_branch_tkn) begin
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_flush = 1'b1;
      end else if (lu_hazard) begin
        ctrl.pc_en      = 1'b0;
        ctrl.ifid_en    = 1'b0;
        ctrl.idex_flush = 1'b1;
      end else if (id_jump) begin
        ctrl.ifid_flush = 1'b1;
      end
      // An aborted access must not write back; a completed one loads MEM/WB
      ctrl.memwb_bubble = timeout;
      mem_timeout       = timeout;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_en      = ctrl.idex_en;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_en     = ctrl.exmem_en;
  assign memwb_bubble = ctrl.memwb_bubble;

  // Next state and wait counter; the counter is zero whenever RUN is entered
  always_comb begin
    state_nxt    = RUN;
    wait_cnt_nxt = '0;
    if (hold) begin
      state_nxt    = MEM_WAIT;
      wait_cnt_nxt = wait_cnt + WC_W'(1);
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_en && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4 and a 4-bit stall counter.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  // Expected output vectors: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_timeout}
  localparam logic [7:0] V_RESET  = 8'b0010_1010;
  localparam logic [7:0] V_NORMAL = 8'b1101_0100;
  localparam logic [7:0] V_LU     = 8'b0001_1100;
  localparam logic [7:0] V_JUMP   = 8'b1111_0100;
  localparam logic [7:0] V_BRANCH = 8'b1111_1100;
  localparam logic [7:0] V_HOLD   = 8'b0000_0010;
  localparam logic [7:0] V_TMO    = 8'b1101_0111;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       ifid_rs, ifid_rt, idex_rt;
  logic             idex_memread, ex_branch_tkn, id_jump, dmem_req, dmem_ready;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic             memwb_bubble, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [7:0]       outs;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ex_branch_tkn(ex_branch_tkn), .id_jump(id_jump),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_timeout};

  task automatic chk_out(input string tag, input logic [7:0] exp);
    ntotal++;
    assert (outs === exp) npass++;
    else $error("FAIL %s: outputs observed %b expected %b", tag, outs, exp);
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp);
    ntotal++;
    assert (stall_cycles === exp) npass++;
    else $error("FAIL %s: stall_cycles observed %0d expected %0d", tag, stall_cycles, exp);
  endtask

  task automatic idle_inputs();
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0; idex_memread = 1'b0;
    ex_branch_tkn = 1'b0; id_jump = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Pass one rising edge and return to the point just after the falling edge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    chk_out("reset_outputs", V_RESET);
    chk_cnt("reset_count", 4'd0);
    step();
    reset = 1'b0;
    #1;
    chk_out("idle_run", V_NORMAL);
    step();
    chk_cnt("idle_no_stall", 4'd0);

    // Load-use on rs: one bubble, then free-running
    idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd3;
    #1; chk_out("lu_rs_stall", V_LU);
    step();
    idex_memread = 1'b0;
    #1; chk_out("lu_after", V_NORMAL);
    chk_cnt("lu_count", 4'd1);

    // Load-use on rt
    idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd3; ifid_rt = 5'd8;
    #1; chk_out("lu_rt_stall", V_LU);
    step();
    idex_rt = 5'd9;
    #1; chk_out("lu_no_match", V_NORMAL);
    chk_cnt("lu_rt_count", 4'd2);

    // Load into $zero never stalls
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    #1; chk_out("zero_load", V_NORMAL);
    step();
    chk_cnt("zero_load_count", 4'd2);
    idle_inputs();

    id_jump = 1'b1;
    #1; chk_out("jump", V_JUMP);
    step();
    id_jump = 1'b0; ex_branch_tkn = 1'b1;
    #1; chk_out("branch", V_BRANCH);
    step();

    // Branch beats a simultaneous load-use and jump; no stall counted
    idex_memread = 1'b1; idex_rt = 5'd12; ifid_rs = 5'd12; id_jump = 1'b1;
    #1; chk_out("branch_over_lu_jump", V_BRANCH);
    step();
    chk_cnt("branch_lu_count", 4'd2);
    idle_inputs();

    // Memory wait: three stalled cycles (branch ignored), then completion
    dmem_req = 1'b1;
    #1; chk_out("mw_cycle1", V_HOLD);
    step();
    ex_branch_tkn = 1'b1;
    #1; chk_out("mw_cycle2_branch_ignored", V_HOLD);
    step();
    ex_branch_tkn = 1'b0;
    #1; chk_out("mw_cycle3", V_HOLD);
    step();
    dmem_ready = 1'b1;
    #1; chk_out("mw_ready", V_NORMAL);
    step();
    chk_cnt("mw_count", 4'd5);
    dmem_req = 1'b0; dmem_ready = 1'b0;

    // Timeout: fourth consecutive wait cycle aborts
    dmem_req = 1'b1;
    #1; chk_out("to_cycle1", V_HOLD);
    step(); chk_out("to_cycle2", V_HOLD);
    step(); chk_out("to_cycle3", V_HOLD);
    step(); chk_out("to_cycle4_abort", V_TMO);
    step();
    dmem_req = 1'b0;
    #1; chk_out("to_back_in_run", V_NORMAL);
    chk_cnt("to_count", 4'd8);
    step();

    // Saturation: eight more stalled cycles from 8 must stop at 15
    idex_memread = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4;
    for (int i = 0; i < 8; i++) step();
    chk_cnt("count_saturate", 4'd15);
    idle_inputs();

    // Async reset during MEM_WAIT
    dmem_req = 1'b1;
    step();
    chk_out("rst_pre_wait", V_HOLD);
    #2 reset = 1'b1;
    #1;
    chk_out("rst_async_outputs", V_RESET);
    chk_cnt("rst_async_count", 4'd0);
    @(negedge clk);
    dmem_req = 1'b0;
    reset = 1'b0;
    #1;
    chk_out("rst_release_run", V_NORMAL);
    step();
    chk_cnt("rst_release_count", 4'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
